// File: rtl/microcode_decoder_pkg.sv
// Shared definitions for the microcode sequencer and decoder: microstep codes,
// bus/ALU encodings, register-load bit positions and the control-word record.
package microcode_decoder_pkg;

   localparam int SM_FETCH0  = 1;
   localparam int SM_FETCH1  = 2;
   localparam int SM_FETCH2  = 3;
   localparam int SM_LD_DR   = 10;
   localparam int SM_INC_AR  = 11;
   localparam int SM_ALU_ADD = 20;
   localparam int SM_ALU_AND = 21;
   localparam int SM_ALU_NOT = 22;
   localparam int SM_ST_AC   = 30;
   localparam int SM_LD_R1   = 31;
   localparam int SM_INC_R1  = 32;
   localparam int SM_LD_R2   = 33;
   localparam int SM_LD_TR   = 34;
   localparam int SM_JMP     = 35;
   localparam int SM_NOP     = 56;
   localparam int SM_HALT    = 57;
   localparam int SM_FIRST   = 1;
   localparam int SM_LAST    = 59;

   localparam logic [3:0] BUS_NONE = 4'd0;
   localparam logic [3:0] BUS_AR   = 4'd1;
   localparam logic [3:0] BUS_PC   = 4'd2;
   localparam logic [3:0] BUS_DR   = 4'd3;
   localparam logic [3:0] BUS_AC   = 4'd4;
   localparam logic [3:0] BUS_IR   = 4'd5;
   localparam logic [3:0] BUS_R1   = 4'd6;
   localparam logic [3:0] BUS_R2   = 4'd7;
   localparam logic [3:0] BUS_TR   = 4'd8;
   localparam logic [3:0] BUS_MEM  = 4'd9;

   localparam int LD_AR = 0;
   localparam int LD_PC = 1;
   localparam int LD_DR = 2;
   localparam int LD_IR = 3;
   localparam int LD_R1 = 4;
   localparam int LD_R2 = 5;
   localparam int LD_TR = 6;
   localparam int LD_AC = 7;

   localparam int INC_PC = 0;
   localparam int INC_AR = 1;
   localparam int INC_R1 = 2;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_OR   = 3'd4;
   localparam logic [2:0] ALU_XOR  = 3'd5;
   localparam logic [2:0] ALU_NOT  = 3'd6;
   localparam logic [2:0] ALU_SHL  = 3'd7;

   typedef struct packed {
      logic [3:0] bus_sel;
      logic [7:0] ld_en;
      logic [2:0] inc_en;
      logic [2:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       alu_we;
   } ctrl_word_t;

   localparam ctrl_word_t CTRL_NOP = '0;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } dec_state_t;

   function automatic logic [7:0] ld_bit(input int idx);
      return 8'b1 << idx;
   endfunction

   function automatic logic [2:0] inc_bit(input int idx);
      return 3'b1 << idx;
   endfunction

endpackage

// File: rtl/microcode_decoder_rom.sv
// Combinational microstep-code to control-word lookup; valid marks codes that
// belong to the table (1..59). Unlisted codes inside that range decode as NOP.
module microcode_rom
   import microcode_decoder_pkg::*;
#(
   parameter int SM_SIG_LEN = 6
) (
   input  logic [SM_SIG_LEN-1:0] code,
   output ctrl_word_t            word,
   output logic                  valid
);

   always_comb begin
      word  = CTRL_NOP;
      valid = (int'(code) >= SM_FIRST) && (int'(code) <= SM_LAST);
      case (int'(code))
         SM_FETCH0:  begin word.bus_sel = BUS_PC;  word.ld_en = ld_bit(LD_AR); end
         SM_FETCH1:  begin word.mem_read = 1'b1;   word.inc_en = inc_bit(INC_PC); end
         SM_FETCH2:  begin word.bus_sel = BUS_MEM; word.ld_en = ld_bit(LD_IR); end
         SM_LD_DR:   begin word.bus_sel = BUS_MEM; word.ld_en = ld_bit(LD_DR); word.mem_read = 1'b1; end
         SM_INC_AR:  word.inc_en = inc_bit(INC_AR);
         SM_ALU_ADD: begin word.bus_sel = BUS_DR; word.alu_op = ALU_ADD; word.ld_en = ld_bit(LD_AC); word.alu_we = 1'b1; end
         SM_ALU_AND: begin word.bus_sel = BUS_DR; word.alu_op = ALU_AND; word.ld_en = ld_bit(LD_AC); word.alu_we = 1'b1; end
         SM_ALU_NOT: begin word.alu_op = ALU_NOT; word.ld_en = ld_bit(LD_AC); word.alu_we = 1'b1; end
         SM_ST_AC:   begin word.bus_sel = BUS_AC; word.mem_write = 1'b1; end
         SM_LD_R1:   begin word.bus_sel = BUS_AC; word.ld_en = ld_bit(LD_R1); end
         SM_INC_R1:  word.inc_en = inc_bit(INC_R1);
         SM_LD_R2:   begin word.bus_sel = BUS_R1; word.ld_en = ld_bit(LD_R2); end
         SM_LD_TR:   begin word.bus_sel = BUS_DR; word.ld_en = ld_bit(LD_TR); end
         SM_JMP:     begin word.bus_sel = BUS_IR; word.ld_en = ld_bit(LD_PC); end
         default:    word = CTRL_NOP;
      endcase
   end

endmodule

// File: rtl/microcode_decoder.sv
// Registered microcode decoder: control word one cycle after the code, sticky
// halt/illegal flags, ALU zero flag capture and a retired-fetch counter.
module microcode_decoder
   import microcode_decoder_pkg::*;
#(
   parameter int SM_SIG_LEN = 6,
   parameter int CNT_LEN    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [SM_SIG_LEN-1:0] smInput,
   input  logic                  aluZero,
   output logic [3:0]            busSel,
   output logic [7:0]            ldEn,
   output logic [2:0]            incEn,
   output logic [2:0]            aluOp,
   output logic                  memRead,
   output logic                  memWrite,
   output logic                  z_in,
   output logic                  halted,
   output logic                  illegal,
   output logic [CNT_LEN-1:0]    instrCount,
   output dec_state_t            fsm_state
);

   dec_state_t   state, state_next;
   ctrl_word_t   rom_word, word_next, ctrl_q;
   logic         rom_valid;
   logic         run, halt_now, fetch_now, bad_now, z_load;

   microcode_rom #(.SM_SIG_LEN(SM_SIG_LEN)) u_rom (
      .code  (smInput),
      .word  (rom_word),
      .valid (rom_valid)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_RUN;
      else        state <= state_next;
   end

   // Halt wins over a pending aluWe so the flag freezes on the halting edge.
   always_comb begin
      state_next = state;
      word_next  = CTRL_NOP;
      run        = start && (state == ST_RUN);
      halt_now   = run && (int'(smInput) == SM_HALT);
      fetch_now  = run && (int'(smInput) == SM_FETCH2);
      bad_now    = run && !rom_valid;
      z_load     = run && !halt_now && ctrl_q.alu_we;
      if (run && rom_valid) word_next = rom_word;
      case (state)
         ST_RUN:    if (halt_now) state_next = ST_HALTED;
         ST_HALTED: state_next = ST_HALTED;
         default:   state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_q     <= CTRL_NOP;
         z_in       <= 1'b0;
         illegal    <= 1'b0;
         instrCount <= '0;
      end else begin
         ctrl_q <= word_next;
         if (z_load)    z_in       <= aluZero;
         if (bad_now)   illegal    <= 1'b1;
         if (fetch_now) instrCount <= instrCount + 1'b1;
      end
   end

   assign busSel    = ctrl_q.bus_sel;
   assign ldEn      = ctrl_q.ld_en;
   assign incEn     = ctrl_q.inc_en;
   assign aluOp     = ctrl_q.alu_op;
   assign memRead   = ctrl_q.mem_read;
   assign memWrite  = ctrl_q.mem_write;
   assign halted    = (state == ST_HALTED);
   assign fsm_state = state;

endmodule

// File: doc/microcode_decoder.md
MICROCODE_DECODER -- requirements
Module: microcode_decoder

Interface
REQ-001 Parameter SM_SIG_LEN, default 6, width of the microstep code.
REQ-002 Parameter CNT_LEN, default 16, width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  run enable, the same signal that drives the sequencer.
REQ-006 smInput  input  SM_SIG_LEN  microstep code from the sequencer.
REQ-007 aluZero  input  1  combinational zero indication from the ALU.
REQ-008 busSel  output  4  bus source select.
REQ-009 ldEn  output  8  one-hot register loads: [0]AR [1]PC [2]DR [3]IR [4]R1 [5]R2 [6]TR [7]AC.
REQ-010 incEn  output  3  increment enables: [0]PC [1]AR [2]R1.
REQ-011 aluOp  output  3  ALU operation; 0 = PASS.
REQ-012 memRead, memWrite  output  1 each  memory strobes.
REQ-013 z_in  output  1  registered zero flag fed back to the sequencer.
REQ-014 halted  output  1  sticky halt indication.
REQ-015 illegal  output  1  sticky unknown-code indication.
REQ-016 instrCount  output  CNT_LEN  count of completed fetches.

Function
REQ-017 The decoder SHALL register every control output, so outputs reflect the smInput sampled on the previous rising edge (latency 1 cycle).
REQ-018 The decode table SHALL map each code to {busSel, ldEn, incEn, aluOp, memRead, memWrite, aluWe}.
REQ-019 The decode table SHALL include these anchor entries:
- 1: busSel=PC, ldEn[0]
- 2: memRead, incEn[0]
- 3: busSel=MEM, ldEn[3]
- 56: NOP (all zero)
- 57: HALT
REQ-020 The NOP word SHALL drive every control output to 0, with busSel=0 and aluOp=PASS.
REQ-021 When start=0, the decoder SHALL drive the NOP word, hold the flags, and leave instrCount unchanged.
REQ-022 For codes absent from the table (0 and 60-63), the decoder SHALL drive NOP and set illegal=1 until reset.
REQ-023 The decoder SHALL implement a two-state FSM:
- RUN to HALTED: when smInput=57 with start=1.
- HALTED is left only by reset.
REQ-024 In HALTED, the decoder SHALL hold halted=1, drive NOP, and freeze z_in and instrCount.
REQ-025 z_in SHALL load aluZero on the edge at which the registered aluWe=1 (one cycle after the ALU microstep); otherwise z_in SHALL hold.
REQ-026 instrCount SHALL increment by 1 on each accepted code 3 and wrap from 2^CNT_LEN-1 to 0.
REQ-027 Codes 1-3 SHALL never assert memWrite.
REQ-028 At most one ldEn bit SHALL be asserted in any cycle; table entries violating this are a design error.
REQ-029 If smInput=57 and aluWe were ever simultaneous, halt SHALL take priority and z_in SHALL not update; the table never defines this combination.

Reset
REQ-030 With reset=0 at a rising edge, the decoder SHALL drive outputs to these values, regardless of start or smInput:
- all control outputs 0
- z_in=0, halted=0, illegal=0, instrCount=0
- FSM=RUN
REQ-031 Reset asserted mid-instruction SHALL take effect on that edge; the next non-reset edge decodes smInput normally.

Structure
REQ-032 A shared package SHALL hold the following; the sequencer uses the same package:
- microstep code constants (1-59)
- busSel encodings
- ldEn bit indices
- aluOp encodings
- the control-word record type
REQ-033 The decode table SHALL be a sub-module, microcode_rom: a combinational code-to-control-word lookup plus a valid bit. Registering, FSM, flags and the counter SHALL live in microcode_decoder.

Verification
REQ-034 Reset low 2 cycles with smInput=1, start=1 -> all outputs 0; first edge after release gives busSel=PC, ldEn=8'h01.
REQ-035 Stream 1,2,3 with start=1 -> outputs track the codes one cycle later; instrCount=1 after code 3; a further 65535 fetches -> instrCount=0 (wrap).
REQ-036 ALU microstep with aluWe, aluZero=1, then aluZero=0 on the next cycle -> z_in=1 two edges after the code and holds during following NOPs.
REQ-037 smInput=57 -> halted=1 on the next edge; subsequent codes 1,2,3 -> NOP outputs, instrCount unchanged; reset pulse -> halted=0.
REQ-038 smInput=0, then 63 -> NOP outputs, illegal=1 and it stays set after valid codes resume; start=0 with smInput=2 -> NOP, no PC increment.
